// File: rtl/mpc_cycle_scheduler_pkg.sv
// Shared Q16.16 constants, the scheduler state encoding and the duty clamp helper.
package mpc_cycle_scheduler_pkg;

  localparam int DW = 32;

  localparam logic [DW-1:0] Q_ONE     = 32'h0001_0000;
  localparam logic [DW-1:0] Q_DC_INIT = Q_ONE >> 1;
  localparam logic [DW-1:0] Q_DC_MIN  = 32'h0000_0CCD;
  localparam logic [DW-1:0] Q_DC_MAX  = 32'h0000_F333;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC_WAIT,
    S_PRED_WAIT,
    S_MPC_WAIT,
    S_UPDATE
  } state_t;

  // Duty is signed Q16.16, so a negative core result must land on the lower bound.
  function automatic logic [DW-1:0] clamp_q16(input logic [DW-1:0] v,
                                              input logic [DW-1:0] lo,
                                              input logic [DW-1:0] hi);
    logic [DW-1:0] r;
    r = v;
    if ($signed(v) < $signed(lo)) r = lo;
    else if ($signed(v) > $signed(hi)) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/mpc_cycle_scheduler_if.sv
// Handshake and operand bundle between the scheduler (master) and ADC/predictor/core/PWM (slave).
interface mpc_cycle_scheduler_if;
  import mpc_cycle_scheduler_pkg::*;

  logic          i_en;
  logic          i_clr_fault;
  logic          o_adc_start;
  logic          i_adc_DV;
  logic [DW-1:0] i_Vpv;
  logic [DW-1:0] i_Ipv;
  logic [DW-1:0] i_Vout;
  logic          o_pred_start;
  logic          i_pred_DV;
  logic [DW-1:0] i_Ipv_plus;
  logic [DW-1:0] i_Ipv_minus;
  logic          o_calc_DV;
  logic [DW-1:0] o_Vpv;
  logic [DW-1:0] o_Ipv;
  logic [DW-1:0] o_Vout;
  logic [DW-1:0] o_Ipv_plus;
  logic [DW-1:0] o_Ipv_minus;
  logic          i_mpc_DV;
  logic [DW-1:0] i_DC_control;
  logic [DW-1:0] o_duty;
  logic          o_duty_upd;
  logic          o_busy;
  logic          o_fault;
  logic [15:0]   o_overrun_cnt;

  modport master (
    input  i_en, i_clr_fault, i_adc_DV, i_Vpv, i_Ipv, i_Vout,
           i_pred_DV, i_Ipv_plus, i_Ipv_minus, i_mpc_DV, i_DC_control,
    output o_adc_start, o_pred_start, o_calc_DV, o_Vpv, o_Ipv, o_Vout,
           o_Ipv_plus, o_Ipv_minus, o_duty, o_duty_upd, o_busy, o_fault, o_overrun_cnt
  );

  modport slave (
    output i_en, i_clr_fault, i_adc_DV, i_Vpv, i_Ipv, i_Vout,
           i_pred_DV, i_Ipv_plus, i_Ipv_minus, i_mpc_DV, i_DC_control,
    input  o_adc_start, o_pred_start, o_calc_DV, o_Vpv, o_Ipv, o_Vout,
           o_Ipv_plus, o_Ipv_minus, o_duty, o_duty_upd, o_busy, o_fault, o_overrun_cnt
  );

endinterface

// File: rtl/mpc_cycle_scheduler_tick_gen.sv
// Control-period counter: o_tick is high combinationally in the last count of each period.
// Dropping i_en restarts the period from zero on the next clock.
module mpc_cycle_scheduler_tick_gen #(
  parameter int PERIOD_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    o_tick = i_en && (cnt_q == LAST);
    cnt_d  = '0;
    if (i_en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mpc_cycle_scheduler.sv
// One MPC control period: ADC -> predictor -> core -> clamped duty, with per-stage watchdog.
// Strobes trail their trigger by 1 clock; ticks arriving while busy are dropped and counted.
module mpc_cycle_scheduler
  import mpc_cycle_scheduler_pkg::*;
#(
  parameter int            PERIOD_CYC  = 1000,
  parameter int            TIMEOUT_CYC = 256,
  parameter logic [DW-1:0] DC_INIT     = Q_DC_INIT,
  parameter logic [DW-1:0] DC_MIN      = Q_DC_MIN,
  parameter logic [DW-1:0] DC_MAX      = Q_DC_MAX
) (
  input logic                   i_clk,
  input logic                   i_rst,
  mpc_cycle_scheduler_if.master bus
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  state_t        state_q;
  logic [WW-1:0] wd_q;
  logic          adc_start_q, pred_start_q, calc_dv_q, duty_upd_q, fault_q;
  logic [15:0]   ovr_q;
  logic [DW-1:0] vpv_q, ipv_q, vout_q, ipp_q, ipm_q, dc_q, duty_q;
  logic          tick;
  logic          wd_exp;

  mpc_cycle_scheduler_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (bus.i_en),
    .o_tick (tick)
  );

  assign wd_exp = (wd_q == WD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      wd_q         <= '0;
      adc_start_q  <= 1'b0;
      pred_start_q <= 1'b0;
      calc_dv_q    <= 1'b0;
      duty_upd_q   <= 1'b0;
      fault_q      <= 1'b0;
      ovr_q        <= '0;
      vpv_q        <= '0;
      ipv_q        <= '0;
      vout_q       <= '0;
      ipp_q        <= '0;
      ipm_q        <= '0;
      dc_q         <= '0;
      duty_q       <= DC_INIT;
    end else begin
      adc_start_q  <= 1'b0;
      pred_start_q <= 1'b0;
      calc_dv_q    <= 1'b0;
      duty_upd_q   <= 1'b0;
      if (bus.i_clr_fault) fault_q <= 1'b0;
      if (tick && (state_q != S_IDLE) && (ovr_q != 16'hFFFF)) ovr_q <= ovr_q + 16'd1;

      // Fault assignments come after the clear above so a coincident timeout wins.
      unique case (state_q)
        S_IDLE: begin
          if (tick && !fault_q) begin
            adc_start_q <= 1'b1;
            wd_q        <= '0;
            state_q     <= S_ADC_WAIT;
          end
        end
        S_ADC_WAIT: begin
          if (bus.i_adc_DV) begin
            vpv_q        <= bus.i_Vpv;
            ipv_q        <= bus.i_Ipv;
            vout_q       <= bus.i_Vout;
            pred_start_q <= 1'b1;
            wd_q         <= '0;
            state_q      <= S_PRED_WAIT;
          end else if (wd_exp) begin
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else wd_q <= wd_q + 1'b1;
        end
        S_PRED_WAIT: begin
          if (bus.i_pred_DV) begin
            ipp_q     <= bus.i_Ipv_plus;
            ipm_q     <= bus.i_Ipv_minus;
            calc_dv_q <= 1'b1;
            wd_q      <= '0;
            state_q   <= S_MPC_WAIT;
          end else if (wd_exp) begin
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else wd_q <= wd_q + 1'b1;
        end
        S_MPC_WAIT: begin
          if (bus.i_mpc_DV) begin
            dc_q    <= bus.i_DC_control;
            state_q <= S_UPDATE;
          end else if (wd_exp) begin
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else wd_q <= wd_q + 1'b1;
        end
        S_UPDATE: begin
          duty_q     <= clamp_q16(dc_q, DC_MIN, DC_MAX);
          duty_upd_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_adc_start   = adc_start_q;
  assign bus.o_pred_start  = pred_start_q;
  assign bus.o_calc_DV     = calc_dv_q;
  assign bus.o_Vpv         = vpv_q;
  assign bus.o_Ipv         = ipv_q;
  assign bus.o_Vout        = vout_q;
  assign bus.o_Ipv_plus    = ipp_q;
  assign bus.o_Ipv_minus   = ipm_q;
  assign bus.o_duty        = duty_q;
  assign bus.o_duty_upd    = duty_upd_q;
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_fault       = fault_q;
  assign bus.o_overrun_cnt = ovr_q;

endmodule

// File: tb/tb_mpc_cycle_scheduler.sv
// Scoreboard bench for mpc_cycle_scheduler: stimulus pushes expected operands/duty, a monitor pops them.
module tb_mpc_cycle_scheduler;

  typedef struct packed {
    logic [31:0] vpv, ipv, vout, ipp, ipm;
  } ops_t;

  localparam int DMIN = 32'h0000_0CCD;
  localparam int DMAX = 32'h0000_F333;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpc_cycle_scheduler_if bus ();

  mpc_cycle_scheduler #(.PERIOD_CYC(20), .TIMEOUT_CYC(50)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0, calc_cnt = 0, adc_cnt = 0;
  logic [31:0] model_duty;
  ops_t        exp_ops[$];
  logic [31:0] exp_duty[$];
  ops_t        mon_e;
  logic [31:0] mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_clamp(input logic [31:0] d);
    int s;
    s = int'(d);
    if (s < DMIN) return DMIN;
    if (s > DMAX) return DMAX;
    return d;
  endfunction

  // Monitor: every strobe from the DUT is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (bus.o_adc_start) adc_cnt++;
    if (bus.o_calc_DV) begin
      calc_cnt++;
      if (exp_ops.size() == 0) begin
        checks++; errors++;
        $display("FAIL calc_unexpected: got o_calc_DV=1 expected no pending operand set");
      end else begin
        mon_e = exp_ops.pop_front();
        chk("op_Vpv", bus.o_Vpv, mon_e.vpv);
        chk("op_Ipv", bus.o_Ipv, mon_e.ipv);
        chk("op_Vout", bus.o_Vout, mon_e.vout);
        chk("op_Ipv_plus", bus.o_Ipv_plus, mon_e.ipp);
        chk("op_Ipv_minus", bus.o_Ipv_minus, mon_e.ipm);
      end
    end
    if (bus.o_duty_upd) begin
      upd_cnt++;
      if (exp_duty.size() == 0) begin
        checks++; errors++;
        $display("FAIL upd_unexpected: got o_duty_upd=1 duty=0x%08h expected no pending update", bus.o_duty);
      end else begin
        mon_d = exp_duty.pop_front();
        chk("duty_on_upd", bus.o_duty, mon_d);
      end
    end
  end

  // which: 0 adc_start, 1 pred_start, 2 calc_DV, 3 duty_upd. DV inputs are single-cycle.
  task automatic wait_sig(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      bus.i_adc_DV = 1'b0; bus.i_pred_DV = 1'b0; bus.i_mpc_DV = 1'b0;
      case (which)
        0:       ok = bus.o_adc_start;
        1:       ok = bus.o_pred_start;
        2:       ok = bus.o_calc_DV;
        default: ok = bus.o_duty_upd;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_strobe_%0d: got no strobe in %0d cycles expected one", which, budget);
    end
  endtask

  // m < 0 leaves the core silent so the watchdog can expire.
  task automatic run_seq(input int a, input int p, input int m,
                         input logic [31:0] vpv, input logic [31:0] ipv, input logic [31:0] vout,
                         input logic [31:0] ipp, input logic [31:0] ipm, input logic [31:0] dc,
                         input bit junk, input bit drop_en);
    bit ok;
    ops_t e;
    wait_sig(0, 200, ok);
    if (!ok) return;
    if (drop_en) bus.i_en = 1'b0;
    repeat (a) @(negedge clk);
    bus.i_Vpv = vpv; bus.i_Ipv = ipv; bus.i_Vout = vout; bus.i_adc_DV = 1'b1;
    if (junk) begin
      bus.i_pred_DV = 1'b1; bus.i_mpc_DV = 1'b1;
      bus.i_Ipv_plus = $urandom; bus.i_Ipv_minus = $urandom; bus.i_DC_control = $urandom;
    end
    wait_sig(1, 10, ok);
    if (!ok) return;
    repeat (p) @(negedge clk);
    bus.i_Ipv_plus = ipp; bus.i_Ipv_minus = ipm; bus.i_pred_DV = 1'b1;
    if (junk) begin
      bus.i_adc_DV = 1'b1; bus.i_mpc_DV = 1'b1;
      bus.i_Vpv = $urandom; bus.i_DC_control = $urandom;
    end
    e = '{vpv, ipv, vout, ipp, ipm};
    exp_ops.push_back(e);
    wait_sig(2, 10, ok);
    if (!ok || m < 0) return;
    repeat (m) @(negedge clk);
    bus.i_DC_control = dc; bus.i_mpc_DV = 1'b1;
    model_duty = model_clamp(dc);
    exp_duty.push_back(model_duty);
    wait_sig(3, 10, ok);
  endtask

  int a, p, m, u0, c0, a0;
  logic [31:0] dc;
  logic [31:0] edge_vals[4];
  bit ok;

  initial begin
    edge_vals = '{32'h0000_0CCC, 32'h0000_0CCD, 32'h0000_F333, 32'h0000_F334};
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_clr_fault = 1'b0;
    bus.i_adc_DV = 1'b0; bus.i_pred_DV = 1'b0; bus.i_mpc_DV = 1'b0;
    bus.i_Vpv = '0; bus.i_Ipv = '0; bus.i_Vout = '0;
    bus.i_Ipv_plus = '0; bus.i_Ipv_minus = '0; bus.i_DC_control = '0;
    model_duty = 32'h0000_8000;
    repeat (3) @(negedge clk);

    chk("rst_duty", bus.o_duty, 32'h0000_8000);
    chk("rst_fault", bus.o_fault, 0);
    chk("rst_overrun", bus.o_overrun_cnt, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_strobes", {bus.o_adc_start, bus.o_pred_start, bus.o_calc_DV, bus.o_duty_upd}, 0);
    chk("rst_operands", bus.o_Vpv | bus.o_Ipv | bus.o_Vout | bus.o_Ipv_plus | bus.o_Ipv_minus, 0);
    rst = 1'b0;
    bus.i_en = 1'b1;

    // Nominal period
    u0 = upd_cnt; c0 = calc_cnt;
    run_seq(3, 2, 2, 32'h0023_0000, 32'hFFE4_32FF, 32'h0030_0000, 32'h0001_2000, 32'h0000_E000,
            32'h0000_C000, 1'b0, 1'b0);
    chk("nom_duty", bus.o_duty, 32'h0000_C000);
    repeat (3) @(negedge clk);
    chk("nom_one_upd", upd_cnt - u0, 1);
    chk("nom_one_calc", calc_cnt - c0, 1);
    chk("nom_fault", bus.o_fault, 0);

    // Clamp boundaries
    run_seq(1, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0001_2000, 1'b0, 1'b0);
    chk("clamp_hi", bus.o_duty, 32'h0000_F333);
    run_seq(1, 1, 1, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA, 32'hFFFF_0000, 1'b0, 1'b0);
    chk("clamp_neg", bus.o_duty, 32'h0000_0CCD);
    run_seq(1, 1, 1, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF, 32'h0000_F333, 1'b0, 1'b0);
    chk("clamp_pass", bus.o_duty, 32'h0000_F333);

    // Randomised periods, short enough never to overrun; junk DVs outside their stage
    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(1, 4); p = $urandom_range(1, 4); m = $urandom_range(1, 6);
      case ($urandom_range(0, 2))
        0:       dc = $urandom;
        1:       dc = 32'h0000_0CCD + $urandom_range(0, 32'hE666);
        default: dc = edge_vals[$urandom_range(0, 3)];
      endcase
      run_seq(a, p, m, $urandom, $urandom, $urandom, $urandom, $urandom, dc,
              1'($urandom_range(0, 1)), 1'b0);
    end
    chk("rand_no_overrun", bus.o_overrun_cnt, 0);

    // Enable dropped mid-sequence
    run_seq(2, 1, 2, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h0000_4000, 1'b0, 1'b1);
    chk("en_drop_duty", bus.o_duty, 32'h0000_4000);
    a0 = adc_cnt;
    repeat (60) @(negedge clk);
    chk("en_drop_no_start", adc_cnt - a0, 0);
    bus.i_en = 1'b1;

    // Overrun: each 51-cycle busy window swallows two ticks
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_duty = 32'h0000_8000;
    run_seq(1, 1, 45, 32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h0000_6000, 1'b0, 1'b0);
    chk("ovr_first", bus.o_overrun_cnt, 2);
    chk("ovr_duty", bus.o_duty, 32'h0000_6000);
    run_seq(1, 1, 45, 32'h25, 32'h26, 32'h27, 32'h28, 32'h29, 32'h0000_7000, 1'b0, 1'b0);
    chk("ovr_second", bus.o_overrun_cnt, 4);

    // Core DV on the watchdog expiry cycle
    run_seq(1, 1, 49, 32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h0000_9000, 1'b0, 1'b0);
    chk("expiry_dv_no_fault", bus.o_fault, 0);
    chk("expiry_dv_duty", bus.o_duty, 32'h0000_9000);
    chk("expiry_overrun", bus.o_overrun_cnt, 6);

    // Timeout in MPC_WAIT
    u0 = upd_cnt;
    run_seq(1, 1, -1, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h0, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    chk("to_not_early", bus.o_fault, 0);
    @(negedge clk);
    chk("to_fault_at_50", bus.o_fault, 1);
    chk("to_idle", bus.o_busy, 0);
    chk("to_duty_held", bus.o_duty, model_duty);
    chk("to_overrun", bus.o_overrun_cnt, 8);
    a0 = adc_cnt;
    repeat (45) @(negedge clk);
    chk("to_no_start", adc_cnt - a0, 0);
    chk("to_no_upd", upd_cnt - u0, 0);
    chk("to_ticks_not_overrun", bus.o_overrun_cnt, 8);
    bus.i_clr_fault = 1'b1;
    @(negedge clk);
    bus.i_clr_fault = 1'b0;
    chk("clr_fault", bus.o_fault, 0);
    run_seq(2, 2, 3, 32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h0000_A000, 1'b0, 1'b0);
    chk("restart_duty", bus.o_duty, 32'h0000_A000);

    // Reset while in PRED_WAIT
    wait_sig(0, 200, ok);
    @(negedge clk);
    bus.i_Vpv = 32'h60; bus.i_adc_DV = 1'b1;
    wait_sig(1, 10, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_duty = 32'h0000_8000;
    chk("prst_duty", bus.o_duty, 32'h0000_8000);
    chk("prst_busy", bus.o_busy, 0);
    chk("prst_overrun", bus.o_overrun_cnt, 0);
    chk("prst_Vpv", bus.o_Vpv, 0);
    bus.i_Ipv_plus = 32'h61; bus.i_pred_DV = 1'b1;
    c0 = calc_cnt;
    repeat (6) @(negedge clk) bus.i_pred_DV = 1'b0;
    chk("late_pred_ignored", calc_cnt - c0, 0);
    chk("late_pred_idle", bus.o_busy, 0);
    chk("late_pred_duty", bus.o_duty, model_duty);

    chk("ops_drained", exp_ops.size(), 0);
    chk("duty_drained", exp_duty.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion expected finish within 2 ms");
    $fatal(1, "global time limit reached");
  end

endmodule
